scan_request_arbiter: RTL and testbench
=======================================

Name: scan_request_arbiter

Overview:
- Shares one scan_controller between NUM_REQ independent requesters, for example a wishbone host, the logic analyser and external pins.
- Each request names a design (select) and its 8 input bits. The arbiter grants one request per scan pass and returns the design's 8 output bits with a done pulse.
- Sits directly in front of scan_controller. It drives that block's active_select/inputs and watches its ready/outputs.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- NUM_DESIGNS, 8, designs on the chain; select values >= NUM_DESIGNS are invalid.
- SEL_W, 9, select width.
- IO_W, 8, inputs/outputs per design.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- req  in  NUM_REQ  per-requester request level.
- req_select  in  NUM_REQ*SEL_W  per-requester design select; slice i is requester i.
- req_inputs  in  NUM_REQ*IO_W  per-requester input bits.
- done  out  NUM_REQ  one-cycle completion pulse per requester.
- rsp_outputs  out  IO_W  outputs returned with done.
- rsp_err  out  1  high with done when the select was invalid.
- rsp_id  out  3  index of the completing requester.
- busy  out  1  a granted request is in flight.
- ctrl_ready  in  1  scan_controller ready.
- ctrl_outputs  in  IO_W  scan_controller outputs.
- ctrl_active_select  out  SEL_W  to scan_controller active_select.
- ctrl_inputs  out  IO_W  to scan_controller inputs.

Behaviour:
- Reset values:
  - done=0, rsp_outputs=0, rsp_err=0, rsp_id=0, busy=0.
  - held select=0, held inputs=0.
  - rr pointer = NUM_REQ-1, so requester 0 has first priority.
  - owner_valid=0, prev_valid=0.
- Pass boundary is any cycle k with ctrl_ready=1. The controller samples inputs at the end of k and updates its outputs at the end of k, so they are valid from k+1.
- Arbitration is round-robin. The winner at cycle k is the first index with req=1 searching upward cyclically from rr pointer+1. The rr pointer moves to the winner only on a grant.
- Controller drive:
  - At cycle k: ctrl_active_select and ctrl_inputs are combinational from the winner's slices. If there is no winner, they take the idle values.
  - At the end of k: the driven values are registered as held values.
  - While ctrl_ready=0: the held values are driven unchanged for the whole pass.
- Ownership:
  - At the end of k: prev_owner<=owner and prev_valid<=owner_valid; then owner<=winner and owner_valid<=(winner exists).
  - busy = owner_valid.
- Response:
  - At the end of k+1, if prev_valid: rsp_outputs<=ctrl_outputs, or 0 if prev_err; rsp_err<=prev_err; rsp_id<=prev_owner; done[prev_owner]<=1.
  - done is high for exactly cycle k+2; all other done bits are 0.
- Latency: done arrives one full pass plus 2 cycles after the granting ready cycle. With the controller at 8 designs x 8 IOs a pass is 258 cycles.
- Invalid select (>= NUM_DESIGNS):
  - The request still wins arbitration and owns the pass.
  - The held select is not changed to it; the previous held value stays.
  - owner_err=1, and it completes with rsp_err=1 and rsp_outputs=0.
- Requester rules:
  - req, req_select and req_inputs are held stable until done.
  - Dropping req before the grant withdraws the request. Dropping it after the grant is ignored; done is still issued.
  - If req is still high after done, it is a new request. Round-robin lets other requesters go first.
- A request sampled at k is never granted twice in the same pass.
- If ctrl_ready stays high for several cycles, each high cycle is a boundary; the controller guarantees single-cycle START.
- Reset mid-pass:
  - All in-flight ownership is discarded and no done is issued.
  - The first ready after reset has prev_valid=0, so no done follows it.

Optional Feature:
- Macro: SCAN_ARB_PARK_EN.
- Defined: an idle pass (no winner) drives ctrl_active_select=9'h1FF and ctrl_inputs=0. 9'h1FF matches no design, so no design's inputs are disturbed.
- Undefined: an idle pass re-drives the last held select and inputs, so the last design keeps being refreshed with the same values.

Decomposition:
- Package scan_arb_pkg holds:
  - SEL_W, IO_W and NUM_DESIGNS defaults;
  - PARK_SELECT=9'h1FF;
  - localparam ID_W=3.
- One sub-module, rr_pick: combinational round-robin picker taking req and pointer, returning winner index and valid.

Test Plan:
- Single request: req[0]=1, select=3, inputs=8'hA5, with a controller model echoing inputs -> done[0] exactly once at the 2nd cycle after the following ready; rsp_outputs=8'hA5, rsp_id=0, rsp_err=0.
- All four requesting with distinct selects 0..3 -> grants in order 0,1,2,3 on consecutive passes; ctrl_active_select stable for each entire pass.
- req[2] held high continuously while req[1] is asserted mid-run -> grant order alternates 2,1,2,1.
- Invalid select=9 on req[1] -> done[1] with rsp_err=1 and rsp_outputs=0; ctrl_active_select keeps its previous value.
- Reset asserted 50 cycles into a granted pass -> no done pulse; first pass after reset grants afresh; done timing is correct afterwards.
- Idle pass with and without SCAN_ARB_PARK_EN -> ctrl_active_select=9'h1FF and inputs=0 with it; last select and inputs without it.

Source files
------------

// File: rtl/scan_request_arbiter_pkg.sv
// ============================================================================
// Module  : scan_arb_pkg
// Purpose : Shared widths, defaults and helper types for scan_request_arbiter.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package scan_arb_pkg;

  localparam int DEF_NUM_REQ     = 4;
  localparam int DEF_NUM_DESIGNS = 8;
  localparam int DEF_SEL_W       = 9;
  localparam int DEF_IO_W        = 8;

  localparam int ID_W = 3;

  localparam logic [8:0] PARK_SELECT = 9'h1FF;

  // Ownership record of one scan pass.
  typedef struct packed {
    logic            valid;
    logic            err;
    logic [ID_W-1:0] id;
  } owner_t;

  function automatic logic [2**ID_W-1:0] id_onehot(input logic [ID_W-1:0] id);
    id_onehot     = '0;
    id_onehot[id] = 1'b1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/scan_request_arbiter_rr_pick.sv
// ============================================================================
// Module  : rr_pick
// Purpose : Combinational round-robin picker; searches upward from ptr_i+1.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_pick
  import scan_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    ptr_i,
  output logic [ID_W-1:0]    idx_o,
  output logic               valid_o
);

  localparam int REQ_SPAN = 2**ID_W;

  logic [REQ_SPAN-1:0] req_ext;
  logic [ID_W-1:0]     cand;

  assign req_ext = REQ_SPAN'(req_i);

  // Walk from the farthest candidate back to the nearest so the last hit wins.
  always_comb begin
    idx_o   = '0;
    valid_o = 1'b0;
    cand    = '0;
    for (int off = NUM_REQ; off >= 1; off--) begin
      cand = ID_W'((int'(ptr_i) + off) % NUM_REQ);
      if (req_ext[cand]) begin
        idx_o   = cand;
        valid_o = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/scan_request_arbiter.sv
// ============================================================================
// Module  : scan_request_arbiter
// Purpose : Round-robin sharing of one scan_controller between NUM_REQ users.
//           Optional macro SCAN_ARB_PARK_EN parks idle passes on PARK_SELECT.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module scan_request_arbiter
  import scan_arb_pkg::*;
#(
  parameter int NUM_REQ     = DEF_NUM_REQ,
  parameter int NUM_DESIGNS = DEF_NUM_DESIGNS,
  parameter int SEL_W       = DEF_SEL_W,
  parameter int IO_W        = DEF_IO_W
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic [NUM_REQ-1:0]       req_i,
  input  logic [NUM_REQ*SEL_W-1:0] req_select_i,
  input  logic [NUM_REQ*IO_W-1:0]  req_inputs_i,
  output logic [NUM_REQ-1:0]       done_o,
  output logic [IO_W-1:0]          rsp_outputs_o,
  output logic                     rsp_err_o,
  output logic [ID_W-1:0]          rsp_id_o,
  output logic                     busy_o,
  input  logic                     ctrl_ready_i,
  input  logic [IO_W-1:0]          ctrl_outputs_i,
  output logic [SEL_W-1:0]         ctrl_active_select_o,
  output logic [IO_W-1:0]          ctrl_inputs_o
);

  logic [ID_W-1:0]    rr_ptr_q;
  logic [ID_W-1:0]    rr_ptr_d;
  logic [ID_W-1:0]    win_idx;
  logic               win_valid;
  logic [SEL_W-1:0]   win_select;
  logic [IO_W-1:0]    win_inputs;
  logic               win_err;

  logic [SEL_W-1:0]   held_select_q;
  logic [IO_W-1:0]    held_inputs_q;
  logic [SEL_W-1:0]   ctrl_select_d;
  logic [IO_W-1:0]    ctrl_inputs_d;

  owner_t             owner_q;
  owner_t             owner_d;
  owner_t             prev_q;
  logic               boundary_q;

  logic [NUM_REQ-1:0] done_q;
  logic [IO_W-1:0]    rsp_outputs_q;
  logic               rsp_err_q;
  logic [ID_W-1:0]    rsp_id_q;

  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_pick (
    .req_i   (req_i),
    .ptr_i   (rr_ptr_q),
    .idx_o   (win_idx),
    .valid_o (win_valid)
  );

  assign win_select = req_select_i[win_idx*SEL_W +: SEL_W];
  assign win_inputs = req_inputs_i[win_idx*IO_W +: IO_W];
  assign win_err    = 32'(win_select) >= 32'(NUM_DESIGNS);

  // An invalid select still owns the pass but must not retarget the chain.
  always_comb begin
    ctrl_select_d = held_select_q;
    ctrl_inputs_d = held_inputs_q;
    if (ctrl_ready_i) begin
      if (win_valid) begin
        if (!win_err) begin
          ctrl_select_d = win_select;
          ctrl_inputs_d = win_inputs;
        end
      end else begin
`ifdef SCAN_ARB_PARK_EN
        ctrl_select_d = SEL_W'(PARK_SELECT);
        ctrl_inputs_d = '0;
`else
        ctrl_select_d = held_select_q;
        ctrl_inputs_d = held_inputs_q;
`endif
      end
    end
  end

  always_comb begin
    owner_d       = '0;
    owner_d.valid = win_valid;
    owner_d.err   = win_valid & win_err;
    owner_d.id    = win_idx;
    rr_ptr_d      = win_valid ? win_idx : rr_ptr_q;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rr_ptr_q      <= ID_W'(NUM_REQ - 1);
      held_select_q <= '0;
      held_inputs_q <= '0;
      owner_q       <= '0;
      prev_q        <= '0;
      boundary_q    <= 1'b0;
      done_q        <= '0;
      rsp_outputs_q <= '0;
      rsp_err_q     <= 1'b0;
      rsp_id_q      <= '0;
    end else begin
      boundary_q <= ctrl_ready_i;
      if (ctrl_ready_i) begin
        held_select_q <= ctrl_select_d;
        held_inputs_q <= ctrl_inputs_d;
        prev_q        <= owner_q;
        owner_q       <= owner_d;
        rr_ptr_q      <= rr_ptr_d;
      end

      // Controller outputs for the finished pass are valid the cycle after START.
      done_q <= '0;
      if (boundary_q && prev_q.valid) begin
        done_q        <= NUM_REQ'(id_onehot(prev_q.id));
        rsp_outputs_q <= prev_q.err ? '0 : ctrl_outputs_i;
        rsp_err_q     <= prev_q.err;
        rsp_id_q      <= prev_q.id;
      end
    end
  end

  assign ctrl_active_select_o = ctrl_select_d;
  assign ctrl_inputs_o        = ctrl_inputs_d;
  assign busy_o               = owner_q.valid;
  assign done_o               = done_q;
  assign rsp_outputs_o        = rsp_outputs_q;
  assign rsp_err_o            = rsp_err_q;
  assign rsp_id_o             = rsp_id_q;

endmodule

`default_nettype wire

// File: tb/tb_scan_request_arbiter.sv
// ============================================================================
// Module  : tb_scan_request_arbiter
// Purpose : Directed bench for scan_request_arbiter with an echoing controller.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_scan_request_arbiter;

  localparam int NR   = 4;
  localparam int SW   = 9;
  localparam int IW   = 8;
  localparam int PASS = 64;

`ifdef SCAN_ARB_PARK_EN
  localparam logic [SW-1:0] EXP_IDLE_SEL = 9'h1FF;
  localparam logic [IW-1:0] EXP_IDLE_IN  = 8'h00;
`else
  localparam logic [SW-1:0] EXP_IDLE_SEL = 9'd5;
  localparam logic [IW-1:0] EXP_IDLE_IN  = 8'h3C;
`endif

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [NR-1:0]    req = '0;
  logic [NR*SW-1:0] req_select = '0;
  logic [NR*IW-1:0] req_inputs = '0;
  logic [NR-1:0]    done;
  logic [IW-1:0]    rsp_outputs;
  logic             rsp_err;
  logic [2:0]       rsp_id;
  logic             busy;
  logic             ctrl_ready;
  logic [IW-1:0]    ctrl_outputs = '0;
  logic [SW-1:0]    ctrl_sel;
  logic [IW-1:0]    ctrl_in;

  logic             ctrl_en = 1'b0;
  int               pcnt = 0;
  logic [IW-1:0]    pass_inputs = '0;

  int               checks = 0;
  int               errors = 0;
  int               cyc_n = 0;
  int               last_rdy = 0;
  int               n_done = 0;
  logic [NR-1:0]    drop_mask = '0;
  logic             stab_on = 1'b0;
  logic             snap_ok = 1'b0;
  logic [SW-1:0]    snap_sel = '0;
  int               stab_err = 0;

  scan_request_arbiter dut (
    .clk_i                (clk),
    .reset_i              (reset),
    .req_i                (req),
    .req_select_i         (req_select),
    .req_inputs_i         (req_inputs),
    .done_o               (done),
    .rsp_outputs_o        (rsp_outputs),
    .rsp_err_o            (rsp_err),
    .rsp_id_o             (rsp_id),
    .busy_o               (busy),
    .ctrl_ready_i         (ctrl_ready),
    .ctrl_outputs_i       (ctrl_outputs),
    .ctrl_active_select_o (ctrl_sel),
    .ctrl_inputs_o        (ctrl_in)
  );

  always #5 clk = ~clk;

  // Controller model: at each START it publishes the inputs of the pass just finished.
  assign ctrl_ready = ctrl_en && (pcnt == 0);
  always @(posedge clk) begin
    if (ctrl_ready) begin
      ctrl_outputs <= pass_inputs;
      pass_inputs  <= ctrl_in;
    end
    pcnt <= (pcnt == PASS - 1) ? 0 : pcnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc_n++;
    if (ctrl_ready) last_rdy = cyc_n;
    if (done != '0) n_done++;
    if (stab_on) begin
      if (ctrl_ready) begin
        snap_sel = ctrl_sel;
        snap_ok  = 1'b1;
      end else if (snap_ok && ctrl_sel != snap_sel) begin
        stab_err++;
      end
    end
    req = req & ~(done & drop_mask);
  endtask

  task automatic set_req(input int i, input logic [SW-1:0] s, input logic [IW-1:0] v,
                         input logic lvl);
    req_select[i*SW +: SW] = s;
    req_inputs[i*IW +: IW] = v;
    req[i]                 = lvl;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic wait_busy(input string tag);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!busy && n < 4*PASS);
    chk({tag, " busy_timeout"}, 32'(!busy), 0);
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!ctrl_ready && n < 4*PASS);
    chk({tag, " ready_timeout"}, 32'(!ctrl_ready), 0);
  endtask

  task automatic wait_done(input string tag, output logic [NR-1:0] d, output logic [IW-1:0] o,
                           output logic e, output logic [2:0] id, output int lat);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (done == '0 && n < 4*PASS);
    chk({tag, " done_timeout"}, 32'(done == '0), 0);
    d   = done;
    o   = rsp_outputs;
    e   = rsp_err;
    id  = rsp_id;
    lat = cyc_n - last_rdy;
  endtask

  initial begin
    logic [NR-1:0] d;
    logic [IW-1:0] o;
    logic          e;
    logic [2:0]    id;
    int            lat;
    int            base;
    int            t3_id[4];
    logic [IW-1:0] t3_out[4];

    t3_id  = '{2, 1, 2, 1};
    t3_out = '{8'h66, 8'h71, 8'h66, 8'h71};

    // Reset state
    step();
    step();
    chk("rst done", done, 0);
    chk("rst rsp_outputs", rsp_outputs, 0);
    chk("rst rsp_err", rsp_err, 0);
    chk("rst rsp_id", rsp_id, 0);
    chk("rst busy", busy, 0);
    chk("rst sel", ctrl_sel, 0);
    chk("rst inputs", ctrl_in, 0);
    reset   = 1'b0;
    ctrl_en = 1'b1;
    step();

    // Single request
    set_req(0, 9'd3, 8'hA5, 1'b1);
    wait_busy("T1");
    req[0] = 1'b0;
    chk("T1 sel_held", ctrl_sel, 3);
    chk("T1 in_held", ctrl_in, 8'hA5);
    base = n_done;
    wait_done("T1", d, o, e, id, lat);
    chk("T1 done", d, 4'b0001);
    chk("T1 out", o, 8'hA5);
    chk("T1 err", e, 0);
    chk("T1 id", id, 0);
    chk("T1 latency", lat, 2);
    repeat (2*PASS) step();
    chk("T1 done_once", n_done - base, 1);

    // All four requesters, grants 0..3 on consecutive passes
    do_reset();
    drop_mask = '1;
    stab_err  = 0;
    snap_ok   = 1'b0;
    stab_on   = 1'b1;
    for (int i = 0; i < NR; i++) set_req(i, SW'(i), IW'(8'h10 + i), 1'b1);
    for (int i = 0; i < NR; i++) begin
      wait_done("T2", d, o, e, id, lat);
      chk("T2 done", d, 4'b0001 << i);
      chk("T2 id", id, i);
      chk("T2 out", o, 8'h10 + i);
    end
    stab_on = 1'b0;
    chk("T2 sel_stable", stab_err, 0);

    // req2 continuous, req1 joins mid-run
    do_reset();
    drop_mask = '0;
    set_req(2, 9'd6, 8'h66, 1'b1);
    wait_done("T3a", d, o, e, id, lat);
    chk("T3 first", d, 4'b0100);
    set_req(1, 9'd7, 8'h71, 1'b1);
    for (int i = 0; i < 4; i++) begin
      wait_done("T3", d, o, e, id, lat);
      chk("T3 id", id, t3_id[i]);
      chk("T3 out", o, t3_out[i]);
    end
    req = '0;

    // Invalid select follows a valid one without an idle pass
    do_reset();
    set_req(0, 9'd5, 8'h3C, 1'b1);
    wait_busy("T4");
    req[0] = 1'b0;
    set_req(1, 9'd9, 8'hFF, 1'b1);
    wait_ready("T4");
    chk("T4 sel_keep", ctrl_sel, 5);
    chk("T4 in_keep", ctrl_in, 8'h3C);
    step();
    req[1] = 1'b0;
    wait_done("T4a", d, o, e, id, lat);
    chk("T4a done", d, 4'b0001);
    chk("T4a out", o, 8'h3C);
    chk("T4a err", e, 0);
    repeat (10) step();
    chk("T4 busy", busy, 1);
    chk("T4 sel_mid", ctrl_sel, 5);
    wait_done("T4b", d, o, e, id, lat);
    chk("T4b done", d, 4'b0010);
    chk("T4b out", o, 0);
    chk("T4b err", e, 1);
    chk("T4b id", id, 1);
    chk("T4b latency", lat, 2);
    chk("idle sel", ctrl_sel, EXP_IDLE_SEL);
    chk("idle in", ctrl_in, EXP_IDLE_IN);
    chk("idle busy", busy, 0);

    // Reset 50 cycles into a granted pass
    do_reset();
    set_req(0, 9'd2, 8'h77, 1'b1);
    wait_busy("T5");
    req[0] = 1'b0;
    repeat (50) step();
    reset = 1'b1;
    step();
    chk("T5 rst busy", busy, 0);
    chk("T5 rst done", done, 0);
    step();
    reset = 1'b0;
    base  = n_done;
    wait_ready("T5");
    repeat (4) step();
    chk("T5 no_done", n_done - base, 0);
    chk("T5 busy_after", busy, 0);
    drop_mask = '1;
    set_req(0, 9'd1, 8'h5A, 1'b1);
    set_req(3, 9'd4, 8'hA3, 1'b1);
    wait_done("T5b", d, o, e, id, lat);
    chk("T5b done", d, 4'b0001);
    chk("T5b out", o, 8'h5A);
    chk("T5b latency", lat, 2);
    wait_done("T5c", d, o, e, id, lat);
    chk("T5c done", d, 4'b1000);
    chk("T5c out", o, 8'hA3);
    chk("T5c id", id, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
